midi_note_rx: RTL and testbench
===============================

// Module: midi_note_rx
// PURPOSE
// - Receives the MIDI serial line (31250 baud, 8N1) and decodes Note On/Note Off messages into a monophonic note.
// - Drives NOTE_NUM/GATE/VELOCITY into the nco voice path.
// - Upstream end of the note interface the oscillator consumes: this block produces NOTE_NUM, nco reads it.
// PARAMETERS
// - CLK_FREQ  100000000  system clock frequency in Hz
// - BAUD      31250      MIDI bit rate; BIT_DIV = CLK_FREQ/BAUD (3200 at defaults)
// - CHANNEL   0          MIDI channel 0..15; used only when MIDI_CHANNEL_FILTER_EN is defined
// PORTS
// - CLK        in   1  system clock, all logic on rising edge
// - RST_N      in   1  asynchronous, active-low reset
// - MIDI_IN    in   1  raw serial line, idle high, asynchronous to CLK
// - NOTE_NUM   out  7  current note number, to nco NOTE_NUM
// - VELOCITY   out  7  velocity of the current note
// - GATE       out  1  high while the current note is held
// - NOTE_STB   out  1  one-cycle pulse on every accepted Note On
// - FRAME_ERR  out  1  one-cycle pulse when a byte has a low stop bit
// BEHAVIOUR
// - Reset: NOTE_NUM=0, VELOCITY=0, GATE=0, NOTE_STB=0, FRAME_ERR=0, parser state IDLE, running status cleared, UART idle.
//   Reset mid-byte or mid-message discards all partial data.
// - UART:
//   - MIDI_IN passes a 2-FF synchronizer.
//   - A falling edge in idle starts the bit counter; start bit is re-sampled at BIT_DIV/2 and, if high, treated as a glitch (return to idle).
//   - Data bits are sampled at the middle of each bit, LSB first; then the stop bit is sampled.
//   - Stop=1: one-cycle byte strobe with the 8-bit value. Stop=0: FRAME_ERR pulse, byte dropped, parser state unchanged.
// - Parser FSM states: IDLE, DATA1, DATA2, SKIP.
//   - 0xF8..0xFF (realtime): ignored in any state; state and running status untouched.
//   - 0x8n or 0x9n: latch status into running status, then go to DATA1.
//   - Any other status byte 0x80..0xF7: clear running status, go to SKIP.
//   - Data byte (<0x80):
//     - IDLE with valid running status: treat as first data byte (go to DATA2).
//     - IDLE with no running status: discard.
//     - SKIP: discard, stay in SKIP.
//     - DATA1: store as key, go to DATA2.
//     - DATA2: store as velocity, execute the message, go to IDLE (running status kept).
// - Execute, registered on the cycle after the DATA2 byte strobe (output latency = 1 clock from strobe):
//   - Note On, vel>0: NOTE_NUM<=key, VELOCITY<=vel, GATE<=1, NOTE_STB pulse. Last-note priority; no note stack.
//   - Note On with vel=0, or Note Off: if key==NOTE_NUM and GATE=1 then GATE<=0; otherwise no change.
//     NOTE_NUM and VELOCITY are held after release.
// - A status byte arriving in DATA1/DATA2 aborts the partial message; the new status is processed normally.
// - All arithmetic is unsigned. Bit counter width is $clog2(BIT_DIV) and it wraps to 0 each bit.
// CONFIGURATION
// - `define MIDI_CHANNEL_FILTER_EN: a Note message executes only if status[3:0]==CHANNEL; other channels are parsed and discarded.
// - Macro undefined: omni mode, all 16 channels accepted.
// STRUCTURE
// - Package midi_pkg:
//   - ST_NOTE_OFF=4'h8, ST_NOTE_ON=4'h9, REALTIME_MIN=8'hF8
//   - parser state encoding localparams
// - Sub-module midi_uart_rx: synchronizer plus 8N1 receiver with byte strobe and frame-error strobe, parameterized by BIT_DIV.
// - Parser FSM and note registers live in midi_note_rx.
// TESTING
// - Reset, then drive bytes 90 3C 64 at 3200 clk/bit -> NOTE_NUM=0x3C, VELOCITY=0x64, GATE=1, one NOTE_STB pulse, 1 clk after the last stop strobe.
// - 90 3C 64 then running status 40 50 -> NOTE_NUM=0x40, VELOCITY=0x50, GATE=1; then 80 3C 00 -> GATE stays 1; then 40 00 -> GATE=0, NOTE_NUM stays 0x40.
// - 90 3C F8 64 (realtime interleaved) -> same result as 90 3C 64; B0 07 7F (CC) -> no output change.
// - Byte with stop bit forced low -> FRAME_ERR pulse, outputs unchanged; 1/4-bit low glitch on idle line -> no byte, no error.
// - With MIDI_CHANNEL_FILTER_EN and CHANNEL=0: 91 3C 64 -> no change; 90 3C 64 -> GATE=1. Without the macro, 91 3C 64 -> GATE=1.
// - Assert RST_N low in the middle of byte 3C of 90 3C 64, release, send 64 -> all outputs 0, GATE=0.

Source files
------------

// File: rtl/midi_pkg.sv
// ---------------------------------------------------------------------------
// midi_pkg
// Shared constants, state encodings and helpers for the MIDI note receiver.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package midi_pkg;

    // Status nibbles of the two channel messages this receiver acts on
    localparam logic [3:0] ST_NOTE_OFF  = 4'h8;
    localparam logic [3:0] ST_NOTE_ON   = 4'h9;

    // Bytes at or above this value are system realtime and never disturb parsing
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    // Message parser states
    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_DATA1 = 2'd1,
        P_DATA2 = 2'd2,
        P_SKIP  = 2'd3
    } parser_state_t;

    // Serial receiver states
    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

    // True for Note Off (0x8n) and Note On (0x9n) status bytes
    function automatic logic is_note_status(input logic [7:0] b);
        return (b[7:4] == ST_NOTE_OFF) || (b[7:4] == ST_NOTE_ON);
    endfunction

endpackage

`default_nettype wire

// File: rtl/midi_uart_rx.sv
// ---------------------------------------------------------------------------
// midi_uart_rx
// Two-flop synchronizer plus 8N1 receiver. Emits a one-cycle byte strobe for
// a good stop bit, or a one-cycle frame-error strobe for a low stop bit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int BIT_DIV = 3200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_stb,
    output logic       frame_err
);

    localparam int             CW        = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(BIT_DIV / 2 - 1);

    logic          sync1;
    logic          sync2;
    logic          sync_prev;
    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Bring the asynchronous line into the clock domain; keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // Receiver: after the start edge, wait half a bit, then sample every full bit at mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= U_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                U_IDLE: begin
                    if (sync_prev && !sync2) begin
                        cnt   <= '0;
                        state <= U_START;
                    end
                end
                U_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        // A line already back high at mid-start is a glitch
                        if (sync2) begin
                            state <= U_IDLE;
                        end else begin
                            bit_idx <= 3'd0;
                            state   <= U_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {sync2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= U_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= U_IDLE;
                        if (sync2) begin
                            data     <= shift;
                            byte_stb <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= U_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/midi_note_rx.sv
// ---------------------------------------------------------------------------
// midi_note_rx
// MIDI receiver that decodes Note On / Note Off (with running status) into a
// monophonic last-note-priority note for the oscillator.
// Optional macro MIDI_CHANNEL_FILTER_EN: act only on messages for CHANNEL;
// when undefined, all 16 channels are accepted.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module midi_note_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 31250,
    parameter int CHANNEL  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       midi_in,
    output logic [6:0] note_num,
    output logic [6:0] velocity,
    output logic       gate,
    output logic       note_stb,
    output logic       frame_err
);

    localparam int         BIT_DIV = CLK_FREQ / BAUD;
    localparam logic [3:0] CH      = 4'(CHANNEL);
`ifdef MIDI_CHANNEL_FILTER_EN
    localparam logic       OMNI    = 1'b0;
`else
    localparam logic       OMNI    = 1'b1;
`endif

    logic [7:0]    rx_byte;
    logic          byte_stb;
    parser_state_t state;
    logic [7:0]    rs_status;
    logic          rs_valid;
    logic [6:0]    key;
    logic          ch_ok;

    midi_uart_rx #(
        .BIT_DIV (BIT_DIV)
    ) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (midi_in),
        .data      (rx_byte),
        .byte_stb  (byte_stb),
        .frame_err (frame_err)
    );

    assign ch_ok = OMNI || (rs_status[3:0] == CH);

    // Parser plus note registers; a completed message updates the outputs on the strobe edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= P_IDLE;
            rs_status <= 8'h00;
            rs_valid  <= 1'b0;
            key       <= 7'd0;
            note_num  <= 7'd0;
            velocity  <= 7'd0;
            gate      <= 1'b0;
            note_stb  <= 1'b0;
        end else begin
            note_stb <= 1'b0;
            if (byte_stb) begin
                if (rx_byte >= REALTIME_MIN) begin
                    // Realtime bytes are transparent to the message stream
                end else if (rx_byte[7]) begin
                    // Any status aborts a partial message
                    if (is_note_status(rx_byte)) begin
                        rs_status <= rx_byte;
                        rs_valid  <= 1'b1;
                        state     <= P_DATA1;
                    end else begin
                        rs_valid <= 1'b0;
                        state    <= P_SKIP;
                    end
                end else begin
                    case (state)
                        P_IDLE: begin
                            if (rs_valid) begin
                                key   <= rx_byte[6:0];
                                state <= P_DATA2;
                            end
                        end
                        P_DATA1: begin
                            key   <= rx_byte[6:0];
                            state <= P_DATA2;
                        end
                        P_DATA2: begin
                            state <= P_IDLE;
                            if (ch_ok) begin
                                if ((rs_status[7:4] == ST_NOTE_ON) && (rx_byte[6:0] != 7'd0)) begin
                                    note_num <= key;
                                    velocity <= rx_byte[6:0];
                                    gate     <= 1'b1;
                                    note_stb <= 1'b1;
                                end else if (gate && (key == note_num)) begin
                                    gate <= 1'b0;
                                end
                            end
                        end
                        P_SKIP: begin
                            state <= P_SKIP;
                        end
                        default: state <= P_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_midi_note_rx.sv
// ---------------------------------------------------------------------------
// tb_midi_note_rx
// Self-checking bench: directed note scenarios plus a random byte stream
// compared against a message-level model of the note receiver.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_midi_note_rx;

    localparam int BAUD     = 31250;
    localparam int BIT      = 16;
    localparam int CLK_FREQ = BAUD * BIT;
    localparam int CHANNEL  = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       midi_in = 1'b1;
    logic [6:0] note_num;
    logic [6:0] velocity;
    logic       gate;
    logic       note_stb;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int stb_cnt = 0;
    int fe_cnt  = 0;

    // Reference model state: current running status (-1 = none) and collected data bytes
    int         m_status = -1;
    int         m_data[$];
    logic [6:0] m_note = 7'd0;
    logic [6:0] m_vel  = 7'd0;
    logic       m_gate = 1'b0;
    int         m_stb  = 0;

    midi_note_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .CHANNEL  (CHANNEL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .midi_in   (midi_in),
        .note_num  (note_num),
        .velocity  (velocity),
        .gate      (gate),
        .note_stb  (note_stb),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (note_stb)  stb_cnt = stb_cnt + 1;
            if (frame_err) fe_cnt  = fe_cnt + 1;
        end
    end

    function automatic void model_exec(input int st, input int k, input int v);
        bit ok;
`ifdef MIDI_CHANNEL_FILTER_EN
        ok = ((st % 16) == CHANNEL);
`else
        ok = 1'b1;
`endif
        if (!ok) return;
        if ((st / 16) == 9 && v != 0) begin
            m_note = 7'(k);
            m_vel  = 7'(v);
            m_gate = 1'b1;
            m_stb  = m_stb + 1;
        end else if (m_gate && m_note == 7'(k)) begin
            m_gate = 1'b0;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'hF8) return;
        if (b >= 8'h80) begin
            m_data.delete();
            m_status = (b < 8'hA0) ? int'(b) : -1;
        end else if (m_status >= 0) begin
            m_data.push_back(int'(b));
            if (m_data.size() == 2) begin
                model_exec(m_status, m_data[0], m_data[1]);
                m_data.delete();
            end
        end
    endfunction

    function automatic void model_reset();
        m_status = -1;
        m_data.delete();
        m_note = 7'd0;
        m_vel  = 7'd0;
        m_gate = 1'b0;
    endfunction

    // Serialise one byte 8N1 (LSB first); a good stop bit also feeds the model
    task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
        midi_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_in = b[i];
            repeat (BIT) @(negedge clk);
        end
        midi_in = stop;
        repeat (BIT) @(negedge clk);
        midi_in = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        if (stop) model_byte(b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        midi_in = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        total++; if (note_num !== 7'd0) begin bad++; $display("FAIL reset note_num: got %h exp 00", note_num); end
        total++; if (velocity !== 7'd0) begin bad++; $display("FAIL reset velocity: got %h exp 00", velocity); end
        total++; if (gate !== 1'b0) begin bad++; $display("FAIL reset gate: got %b exp 0", gate); end
        total++; if (note_stb !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL reset strobes: got %b%b exp 00", note_stb, frame_err); end
    endtask

    task automatic test_note_on();
        int s0 = stb_cnt;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        total++; if ({note_num, velocity, gate} !== {7'h3C, 7'h64, 1'b1}) begin bad++; $display("FAIL note_on: got %h/%h/%b exp 3c/64/1", note_num, velocity, gate); end
        total++; if (stb_cnt !== s0 + 1) begin bad++; $display("FAIL note_on stb count: got %0d exp %0d", stb_cnt - s0, 1); end
    endtask

    task automatic test_running_status();
        int s0 = stb_cnt;
        send_byte(8'h40); send_byte(8'h50);
        total++; if ({note_num, velocity, gate} !== {7'h40, 7'h50, 1'b1}) begin bad++; $display("FAIL running_on: got %h/%h/%b exp 40/50/1", note_num, velocity, gate); end
        total++; if (stb_cnt !== s0 + 1) begin bad++; $display("FAIL running stb count: got %0d exp %0d", stb_cnt - s0, 1); end
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        total++; if ({note_num, velocity, gate} !== {7'h40, 7'h50, 1'b1}) begin bad++; $display("FAIL off_other_key: got %h/%h/%b exp 40/50/1", note_num, velocity, gate); end
        send_byte(8'h40); send_byte(8'h00);
        total++; if ({note_num, velocity, gate} !== {7'h40, 7'h50, 1'b0}) begin bad++; $display("FAIL off_running: got %h/%h/%b exp 40/50/0", note_num, velocity, gate); end
    endtask

    task automatic test_realtime_and_cc();
        int s0 = stb_cnt;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        total++; if ({note_num, velocity, gate} !== {7'h3C, 7'h64, 1'b1}) begin bad++; $display("FAIL realtime: got %h/%h/%b exp 3c/64/1", note_num, velocity, gate); end
        total++; if (stb_cnt !== s0 + 1) begin bad++; $display("FAIL realtime stb count: got %0d exp %0d", stb_cnt - s0, 1); end
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'h7F); send_byte(8'h3C); send_byte(8'h00);
        total++; if ({note_num, velocity, gate} !== {7'h3C, 7'h64, 1'b1}) begin bad++; $display("FAIL cc_ignored: got %h/%h/%b exp 3c/64/1", note_num, velocity, gate); end
    endtask

    task automatic test_frame_and_glitch();
        int f0 = fe_cnt;
        int s0 = stb_cnt;
        send_byte(8'h80, 1'b0);
        total++; if (fe_cnt !== f0 + 1) begin bad++; $display("FAIL frame_err count: got %0d exp %0d", fe_cnt - f0, 1); end
        total++; if ({note_num, velocity, gate} !== {7'h3C, 7'h64, 1'b1}) begin bad++; $display("FAIL frame_outputs: got %h/%h/%b exp 3c/64/1", note_num, velocity, gate); end
        midi_in = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        midi_in = 1'b1;
        repeat (BIT) @(negedge clk);
        send_byte(8'h90); send_byte(8'h3D); send_byte(8'h70);
        total++; if ({note_num, velocity, gate} !== {7'h3D, 7'h70, 1'b1}) begin bad++; $display("FAIL after_glitch: got %h/%h/%b exp 3d/70/1", note_num, velocity, gate); end
        total++; if (fe_cnt !== f0 + 1 || stb_cnt !== s0 + 1) begin bad++; $display("FAIL glitch counts: got fe=%0d stb=%0d exp fe=1 stb=1", fe_cnt - f0, stb_cnt - s0); end
    endtask

    task automatic test_channel();
        send_byte(8'h80); send_byte(8'h3D); send_byte(8'h00);
        total++; if (gate !== 1'b0 || note_num !== 7'h3D) begin bad++; $display("FAIL release: got %h/%b exp 3d/0", note_num, gate); end
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
`ifdef MIDI_CHANNEL_FILTER_EN
        total++; if ({note_num, velocity, gate} !== {7'h3D, 7'h70, 1'b0}) begin bad++; $display("FAIL other_channel: got %h/%h/%b exp 3d/70/0", note_num, velocity, gate); end
`else
        total++; if ({note_num, velocity, gate} !== {7'h3C, 7'h64, 1'b1}) begin bad++; $display("FAIL omni_channel: got %h/%h/%b exp 3c/64/1", note_num, velocity, gate); end
`endif
        send_byte(8'h90); send_byte(8'h3E); send_byte(8'h22);
        total++; if ({note_num, velocity, gate} !== {7'h3E, 7'h22, 1'b1}) begin bad++; $display("FAIL own_channel: got %h/%h/%b exp 3e/22/1", note_num, velocity, gate); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] b = 8'h3C;
        int s0;
        send_byte(8'h90);
        midi_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            midi_in = b[i];
            repeat (BIT) @(negedge clk);
        end
        rst_n = 1'b0;
        midi_in = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({note_num, velocity, gate} !== 15'd0) begin bad++; $display("FAIL async_reset: got %h/%h/%b exp 00/00/0", note_num, velocity, gate); end
        rst_n = 1'b1;
        model_reset();
        repeat (BIT) @(negedge clk);
        s0 = stb_cnt;
        send_byte(8'h64);
        total++; if ({note_num, velocity, gate} !== 15'd0) begin bad++; $display("FAIL reset_discard: got %h/%h/%b exp 00/00/0", note_num, velocity, gate); end
        total++; if (stb_cnt !== s0) begin bad++; $display("FAIL reset_discard stb: got %0d exp 0", stb_cnt - s0); end
    endtask

    task automatic test_random_stream();
        logic [7:0] b;
        int r;
        int f0 = fe_cnt;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      b = {4'h9, 4'($urandom_range(0, 1))};
            else if (r < 30) b = {4'h8, 4'($urandom_range(0, 1))};
            else if (r < 36) b = 8'($urandom_range(8'hA0, 8'hF7));
            else if (r < 42) b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 55) b = 8'h00;
            else if (r < 65) b = 8'($urandom_range(0, 127));
            else             b = 8'($urandom_range(8'h3C, 8'h3F));
            send_byte(b);
            total++;
            if ({note_num, velocity, gate} !== {m_note, m_vel, m_gate}) begin
                bad++;
                $display("FAIL random[%0d] byte %h: got %h/%h/%b exp %h/%h/%b", n, b, note_num, velocity, gate, m_note, m_vel, m_gate);
            end
            total++;
            if (stb_cnt !== m_stb) begin
                bad++;
                $display("FAIL random[%0d] stb count: got %0d exp %0d", n, stb_cnt, m_stb);
            end
        end
        total++; if (fe_cnt !== f0) begin bad++; $display("FAIL random frame errors: got %0d exp 0", fe_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime_and_cc();
        test_frame_and_glitch();
        test_channel();
        test_reset_mid_byte();
        m_stb = stb_cnt;
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
